// File: rtl/ins_fetch.sv
// ---------------------------------------------------------------------------
// ins_fetch -- front-end instruction fetch stage
//
// Holds the architectural fetch PC, issues one icache request at a time,
// predicts the next fetch PC from the returned instruction (plus the branch
// predictor's verdict), and offers {inst, pc, pred_jump} to the decoder over
// a valid/ready handshake. A RoB flush redirects fetch to a new PC and
// throws away whatever is in flight.
//
// Ports
//   clk_in, rst_in, rdy_in        clock, synchronous active-high reset,
//                                 global enable (low = hold everything)
//   ic_req_valid/addr/ready       fetch request to the icache
//   ic_rsp_valid/inst             one-cycle response pulse from the icache
//   if_pc, tojump                 PC sent to the predictor, its verdict
//   out_valid/ready               instruction slot handshake to the decoder
//   out_inst/pc/pred_jump         slot contents
//   rob_flush, rob_flush_pc       redirect request from the RoB
// ---------------------------------------------------------------------------
module ins_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        ic_req_valid,
  output logic [31:0] ic_req_addr,
  input  logic        ic_req_ready,
  input  logic        ic_rsp_valid,
  input  logic [31:0] ic_rsp_inst,
  output logic [31:0] if_pc,
  input  logic        tojump,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_pred_jump,
  input  logic        rob_flush,
  input  logic [31:0] rob_flush_pc
);

  // REQ: request pending, WAIT: awaiting response, OUT: slot full,
  // DISCARD: a request was made stale by a flush and its response must be
  // swallowed before a new request can go out.
  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_OUT,
    ST_DISCARD
  } state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_nextPc;
  logic        r_icReqValid;
  logic        r_outValid;
  logic [31:0] r_outInst;
  logic [31:0] r_outPc;
  logic        r_outPredJump;

  logic [6:0]  w_opcode;
  logic [31:0] w_immJ;
  logic [31:0] w_immB;
  logic [31:0] w_seqPc;
  logic [31:0] w_predNextPc;
  logic        w_predJump;
  logic        w_reqAccept;

  // A request only counts as accepted when we were actually offering one;
  // right after reset ic_req_valid is low even though the state is REQ.
  assign w_reqAccept = r_icReqValid & ic_req_ready;

  // Immediate extraction for the two PC-relative control-flow formats.
  assign w_opcode = ic_rsp_inst[6:0];
  assign w_immJ   = {{11{ic_rsp_inst[31]}}, ic_rsp_inst[31], ic_rsp_inst[19:12],
                     ic_rsp_inst[20], ic_rsp_inst[30:21], 1'b0};
  assign w_immB   = {{19{ic_rsp_inst[31]}}, ic_rsp_inst[31], ic_rsp_inst[7],
                     ic_rsp_inst[30:25], ic_rsp_inst[11:8], 1'b0};
  assign w_seqPc  = r_pc + 32'd4;

  // Next-PC prediction for the instruction being returned right now. JAL is
  // always followed, conditional branches follow the predictor, and JALR is
  // left sequential because its target is only known at execute.
  always_comb begin
    w_predNextPc = w_seqPc;
    w_predJump   = 1'b0;
    case (w_opcode)
      OP_JAL: begin
        w_predNextPc = r_pc + w_immJ;
        w_predJump   = 1'b1;
      end
      OP_BRANCH: begin
        if (tojump) begin
          w_predNextPc = r_pc + w_immB;
          w_predJump   = 1'b1;
        end
      end
      OP_JALR: begin
        w_predNextPc = w_seqPc;
        w_predJump   = 1'b0;
      end
      default: begin
        w_predNextPc = w_seqPc;
        w_predJump   = 1'b0;
      end
    endcase
  end

  // Fetch control. Reset beats everything; with rdy_in low nothing moves.
  // A flush always loads the new PC and empties the slot; the only question
  // is whether an icache request is still in flight (-> DISCARD) or not
  // (-> REQ). The predicted next PC is captured together with the slot so the
  // OUT state never looks at tojump again.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state       <= ST_REQ;
      r_pc          <= RESET_PC;
      r_nextPc      <= RESET_PC;
      r_icReqValid  <= 1'b0;
      r_outValid    <= 1'b0;
      r_outInst     <= 32'd0;
      r_outPc       <= 32'd0;
      r_outPredJump <= 1'b0;
    end else if (rdy_in) begin
      if (rob_flush) begin
        r_pc       <= rob_flush_pc;
        r_outValid <= 1'b0;
        case (r_state)
          ST_REQ: begin
            if (w_reqAccept) begin
              r_state      <= ST_DISCARD;
              r_icReqValid <= 1'b0;
            end else begin
              r_state      <= ST_REQ;
              r_icReqValid <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (ic_rsp_valid) begin
              r_state      <= ST_REQ;
              r_icReqValid <= 1'b1;
            end else begin
              r_state      <= ST_DISCARD;
              r_icReqValid <= 1'b0;
            end
          end
          ST_OUT: begin
            r_state      <= ST_REQ;
            r_icReqValid <= 1'b1;
          end
          ST_DISCARD: begin
            if (ic_rsp_valid) begin
              r_state      <= ST_REQ;
              r_icReqValid <= 1'b1;
            end
          end
          default: begin
            r_state      <= ST_REQ;
            r_icReqValid <= 1'b1;
          end
        endcase
      end else begin
        case (r_state)
          ST_REQ: begin
            if (w_reqAccept) begin
              r_state      <= ST_WAIT;
              r_icReqValid <= 1'b0;
            end else begin
              r_icReqValid <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (ic_rsp_valid) begin
              r_state       <= ST_OUT;
              r_outValid    <= 1'b1;
              r_outInst     <= ic_rsp_inst;
              r_outPc       <= r_pc;
              r_outPredJump <= w_predJump;
              r_nextPc      <= w_predNextPc;
            end
          end
          ST_OUT: begin
            if (out_ready) begin
              r_state      <= ST_REQ;
              r_outValid   <= 1'b0;
              r_pc         <= r_nextPc;
              r_icReqValid <= 1'b1;
            end
          end
          ST_DISCARD: begin
            if (ic_rsp_valid) begin
              r_state      <= ST_REQ;
              r_icReqValid <= 1'b1;
            end
          end
          default: begin
            r_state      <= ST_REQ;
            r_icReqValid <= 1'b1;
          end
        endcase
      end
    end
  end

  assign ic_req_valid  = r_icReqValid;
  assign ic_req_addr   = r_pc;
  assign if_pc         = r_pc;
  assign out_valid     = r_outValid;
  assign out_inst      = r_outInst;
  assign out_pc        = r_outPc;
  assign out_pred_jump = r_outPredJump;

endmodule

// File: tb/tb_ins_fetch.sv
// ---------------------------------------------------------------------------
// tb_ins_fetch -- self-checking bench for ins_fetch
//
// Directed vector table for next-PC prediction, hand-written sequences for
// back-pressure, flush and enable corner cases, then a randomized run
// checked against a transaction-level model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_ins_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        rdy;
  logic        icReqValid;
  logic [31:0] icReqAddr;
  logic        icReqReady;
  logic        icRspValid;
  logic [31:0] icRspInst;
  logic [31:0] ifPc;
  logic        toJump;
  logic        outValid;
  logic        outReady;
  logic [31:0] outInst;
  logic [31:0] outPc;
  logic        outPredJump;
  logic        robFlush;
  logic [31:0] robFlushPc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        tj;
    logic [31:0] expNext;
    logic        expPj;
  } vec_t;

  vec_t vecs[9];

  ins_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_in       (clock),
    .rst_in       (reset),
    .rdy_in       (rdy),
    .ic_req_valid (icReqValid),
    .ic_req_addr  (icReqAddr),
    .ic_req_ready (icReqReady),
    .ic_rsp_valid (icRspValid),
    .ic_rsp_inst  (icRspInst),
    .if_pc        (ifPc),
    .tojump       (toJump),
    .out_valid    (outValid),
    .out_ready    (outReady),
    .out_inst     (outInst),
    .out_pc       (outPc),
    .out_pred_jump(outPredJump),
    .rob_flush    (robFlush),
    .rob_flush_pc (robFlushPc)
  );

  always #5 clock = ~clock;

  // One comparison: count it, and report a mismatch with both values.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, let the rising edge act,
  // and return at the next falling edge where outputs are stable.
  task automatic applyStimulus(input logic rst, input logic rd, input logic reqRdy,
                               input logic rspV, input logic [31:0] inst, input logic tj,
                               input logic oRdy, input logic fl, input logic [31:0] flPc);
    reset      = rst;
    rdy        = rd;
    icReqReady = reqRdy;
    icRspValid = rspV;
    icRspInst  = inst;
    toJump     = tj;
    outReady   = oRdy;
    robFlush   = fl;
    robFlushPc = flPc;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Reference next-PC rule, with immediates rebuilt arithmetically from the
  // instruction fields.
  function automatic void refNext(input logic [31:0] pc, input logic [31:0] inst, input logic tj,
                                  output logic [31:0] nxt, output logic pj);
    int imm;
    imm = 0;
    case (inst[6:0])
      7'b1101111: begin
        imm = int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
        if (inst[31]) imm = imm - 1048576;
        nxt = pc + imm;
        pj  = 1'b1;
      end
      7'b1100011: begin
        imm = int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
        if (inst[31]) imm = imm - 4096;
        nxt = tj ? pc + imm : pc + 32'd4;
        pj  = tj;
      end
      default: begin
        nxt = pc + 32'd4;
        pj  = 1'b0;
      end
    endcase
  endfunction

  // Model state for the random phase.
  logic [31:0] mPc;
  logic [31:0] mReqPc;
  logic [31:0] mNext;
  logic        mOut;
  logic        mStale;
  logic        mSlot;
  logic        mJustReset;
  logic [31:0] slotInst;
  logic [31:0] slotPc;
  logic        slotPj;
  int          mDelay;
  int          transfers;

  initial begin
    vecs[0] = '{"addi",      32'h0010_0093, 32'h0000_0000, 1'b0, 32'h0000_0004, 1'b0};
    vecs[1] = '{"jal+20",    32'h0200_006F, 32'h0000_0010, 1'b0, 32'h0000_0030, 1'b1};
    vecs[2] = '{"beq-8 t",   32'hFE00_0CE3, 32'h0000_0040, 1'b1, 32'h0000_0038, 1'b1};
    vecs[3] = '{"beq-8 nt",  32'hFE00_0CE3, 32'h0000_0040, 1'b0, 32'h0000_0044, 1'b0};
    vecs[4] = '{"jalr",      32'h0000_80E7, 32'h0000_0080, 1'b1, 32'h0000_0084, 1'b0};
    vecs[5] = '{"jal wrap",  32'h0200_006F, 32'hFFFF_FFF0, 1'b0, 32'h0000_0010, 1'b1};
    vecs[6] = '{"beq wrap",  32'hFE00_0CE3, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC, 1'b1};
    vecs[7] = '{"nop tj",    32'h0000_0013, 32'h0000_0200, 1'b1, 32'h0000_0204, 1'b0};
    vecs[8] = '{"jal-4",     32'hFFDF_F06F, 32'h0000_0100, 1'b0, 32'h0000_00FC, 1'b1};

    // Reset state and the first request.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("rst reqValid", {31'd0, icReqValid}, 32'd0);
    checkOutput("rst outValid", {31'd0, outValid}, 32'd0);
    checkOutput("rst outInst", outInst, 32'd0);
    checkOutput("rst outPc", outPc, 32'd0);
    checkOutput("rst outPj", {31'd0, outPredJump}, 32'd0);
    checkOutput("rst reqAddr", icReqAddr, 32'd0);
    idle();
    checkOutput("first reqValid", {31'd0, icReqValid}, 32'd1);
    checkOutput("first reqAddr", icReqAddr, 32'd0);

    // Table: redirect to the vector's PC, fetch it, transfer, check next PC.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, vecs[i].pc);
      checkOutput({vecs[i].name, " reqAddr"}, icReqAddr, vecs[i].pc);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, vecs[i].inst, vecs[i].tj, 1'b0, 1'b0, 32'd0);
      checkOutput({vecs[i].name, " outPc"}, outPc, vecs[i].pc);
      checkOutput({vecs[i].name, " outInst"}, outInst, vecs[i].inst);
      checkOutput({vecs[i].name, " outPj"}, {31'd0, outPredJump}, {31'd0, vecs[i].expPj});
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
      checkOutput({vecs[i].name, " nextValid"}, {31'd0, icReqValid}, 32'd1);
      checkOutput({vecs[i].name, " nextAddr"}, icReqAddr, vecs[i].expNext);
    end

    // Back-pressure: slot stays put and no request goes out while full.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h300);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold outValid", {31'd0, outValid}, 32'd1);
      checkOutput("hold outPc", outPc, 32'h300);
      checkOutput("hold outInst", outInst, 32'h0010_0093);
      checkOutput("hold reqValid", {31'd0, icReqValid}, 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("release outValid", {31'd0, outValid}, 32'd0);
    checkOutput("release reqValid", {31'd0, icReqValid}, 32'd1);
    checkOutput("release reqAddr", icReqAddr, 32'h304);

    // Flush while waiting; the late response must be dropped.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h100);
    checkOutput("discard reqValid", {31'd0, icReqValid}, 32'd0);
    checkOutput("discard ifPc", ifPc, 32'h100);
    idle();
    checkOutput("discard2 outValid", {31'd0, outValid}, 32'd0);
    checkOutput("discard2 reqValid", {31'd0, icReqValid}, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("dropped outValid", {31'd0, outValid}, 32'd0);
    checkOutput("after drop reqValid", {31'd0, icReqValid}, 32'd1);
    checkOutput("after drop reqAddr", icReqAddr, 32'h100);

    // Flush coinciding with the response.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 1'b1, 32'h200);
    checkOutput("flush+rsp outValid", {31'd0, outValid}, 32'd0);
    checkOutput("flush+rsp reqValid", {31'd0, icReqValid}, 32'd1);
    checkOutput("flush+rsp reqAddr", icReqAddr, 32'h200);

    // rdy_in low mid-wait: nothing may move even with response and flush.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h0200_006F, 1'b1, 1'b1, 1'b1, 32'h777);
      checkOutput("stall outValid", {31'd0, outValid}, 32'd0);
      checkOutput("stall reqValid", {31'd0, icReqValid}, 32'd0);
      checkOutput("stall ifPc", ifPc, 32'h200);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0010_0093, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("resume outValid", {31'd0, outValid}, 32'd1);
    checkOutput("resume outPc", outPc, 32'h200);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd0);
    checkOutput("resume nextAddr", icReqAddr, 32'h204);

    // Flush in the same cycle a request is accepted: that request is stale.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h500);
    checkOutput("stale reqValid", {31'd0, icReqValid}, 32'd0);
    checkOutput("stale ifPc", ifPc, 32'h500);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0200_006F, 1'b0, 1'b0, 1'b0, 32'd0);
    checkOutput("stale outValid", {31'd0, outValid}, 32'd0);
    checkOutput("stale reqAddr", icReqAddr, 32'h500);

    // Reset wins over a simultaneous flush.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 32'h900);
    checkOutput("rst>flush addr", icReqAddr, 32'd0);
    checkOutput("rst>flush reqValid", {31'd0, icReqValid}, 32'd0);

    // Randomized run against the transaction model.
    mPc = 32'd0; mReqPc = 32'd0; mNext = 32'd0;
    mOut = 1'b0; mStale = 1'b0; mSlot = 1'b0; mJustReset = 1'b1;
    slotInst = 32'd0; slotPc = 32'd0; slotPj = 1'b0;
    mDelay = 0; transfers = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      logic        rRst, rRdy, rReqRdy, rRspV, rTj, rORdy, rFl, accepted;
      logic [31:0] rInst, rFlPc;
      logic        mReqExp;

      mReqExp = !mOut && !mSlot && !mJustReset;
      checkOutput("rnd outValid", {31'd0, outValid}, {31'd0, mSlot});
      checkOutput("rnd reqValid", {31'd0, icReqValid}, {31'd0, mReqExp});
      checkOutput("rnd ifPc", ifPc, mPc);
      if (mReqExp) checkOutput("rnd reqAddr", icReqAddr, mPc);
      if (mSlot) begin
        checkOutput("rnd outInst", outInst, slotInst);
        checkOutput("rnd outPc", outPc, slotPc);
        checkOutput("rnd outPj", {31'd0, outPredJump}, {31'd0, slotPj});
      end

      rRst    = ($urandom_range(0, 199) == 0);
      rRdy    = ($urandom_range(0, 9) != 0);
      rReqRdy = ($urandom_range(0, 1) == 1);
      rRspV   = mOut && (mDelay == 0);
      rInst   = $urandom();
      case ($urandom_range(0, 3))
        0: rInst[6:0] = 7'b1101111;
        1: rInst[6:0] = 7'b1100011;
        2: rInst[6:0] = 7'b1100111;
        default: rInst[6:0] = 7'b0010011;
      endcase
      rTj   = ($urandom_range(0, 1) == 1);
      rORdy = ($urandom_range(0, 4) < 3);
      rFl   = ($urandom_range(0, 19) == 0);
      rFlPc = $urandom() & 32'hFFFF_FFFC;
      accepted = icReqValid && rReqRdy;

      if (rRst) begin
        mPc = 32'd0; mOut = 1'b0; mStale = 1'b0; mSlot = 1'b0; mJustReset = 1'b1;
      end else if (rRdy) begin
        mJustReset = 1'b0;
        if (rFl) begin
          if (rRspV) begin
            mOut = 1'b0; mStale = 1'b0;
          end else if (accepted) begin
            mOut = 1'b1; mStale = 1'b1; mDelay = $urandom_range(0, 3);
          end else if (mOut) begin
            mStale = 1'b1;
          end
          mSlot = 1'b0;
          mPc   = rFlPc;
        end else begin
          if (mSlot && rORdy) begin
            transfers++;
            mPc   = mNext;
            mSlot = 1'b0;
          end
          if (rRspV) begin
            mOut = 1'b0;
            if (!mStale) begin
              mSlot    = 1'b1;
              slotInst = rInst;
              slotPc   = mReqPc;
              refNext(mReqPc, rInst, rTj, mNext, slotPj);
            end
            mStale = 1'b0;
          end
          if (accepted) begin
            mOut   = 1'b1;
            mStale = 1'b0;
            mReqPc = mPc;
            mDelay = $urandom_range(0, 3);
          end else if (mOut && !rRspV && mDelay > 0) begin
            mDelay--;
          end
        end
      end
      applyStimulus(rRst, rRdy, rReqRdy, rRspV, rInst, rTj, rORdy, rFl, rFlPc);
    end
    checkOutput("rnd progress", {31'd0, (transfers > 50)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
